// File: rtl/serial_magnitude_compare.sv
// serial_magnitude_compare
// Multi-cycle magnitude comparator. Scans two N-bit operands MSB-first, K bits
// per clock, and stops early at the first digit that differs.
// It supports six relational modes (EQ, NE, GT, GE, LT, LE) and uses a
// start/done handshake.
//
// Optional feature macro: SIGNED_COMPARE_EN (adds the sgn port and a
// two's-complement compare mode).
//
// Parameters:
//   N     operand width in bits (N >= 1)
//   K     digit width, bits compared per cycle (K >= 1, N % K == 0)
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   start request, sampled only in IDLE
//   a, b  operands, captured when start is accepted
//   op    relation: 000 EQ, 001 NE, 010 GT, 011 GE, 100 LT, 101 LE,
//         110/111 reserved (c=0)
//   sgn   two's-complement compare when high (SIGNED_COMPARE_EN only)
//   busy  high whenever the FSM is not idle
//   done  one-cycle pulse; results are valid from this cycle on
//   c     result of a op b
//   gt, eq, lt  raw ordering flags, one-hot after a completed compare
module serial_magnitude_compare #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
`ifdef SIGNED_COMPARE_EN
  input  logic         sgn,
`endif
  output logic         busy,
  output logic         done,
  output logic         c,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int unsigned D  = N / K;
  localparam int unsigned CW = $clog2(D + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  sa, sa_n, sb, sb_n;
  logic [2:0]    op_q, op_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          busy_n, done_n, c_n, gt_n, eq_n, lt_n;
  logic [N-1:0]  cap_a, cap_b;
  logic [K-1:0]  da, db;

  // Evaluate the selected relation from the ordering flags.
  function automatic logic rel(input logic [2:0] o, input logic g,
                               input logic e, input logic l);
    logic r;
    case (o)
      3'b000:  r = e;
      3'b001:  r = ~e;
      3'b010:  r = g;
      3'b011:  r = g | e;
      3'b100:  r = l;
      3'b101:  r = l | e;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sa    <= '0;
      sb    <= '0;
      op_q  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      op_q  <= op_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      c     <= c_n;
      gt    <= gt_n;
      eq    <= eq_n;
      lt    <= lt_n;
    end
  end

  // Operand capture. In signed mode the MSB is flipped (offset binary), so
  // the unsigned scan yields the two's-complement ordering.
  always_comb begin
    cap_a = a;
    cap_b = b;
`ifdef SIGNED_COMPARE_EN
    cap_a[N-1] = a[N-1] ^ sgn;
    cap_b[N-1] = b[N-1] ^ sgn;
`endif
  end

  assign da = sa[N-1 -: K];
  assign db = sb[N-1 -: K];

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    op_n    = op_q;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    c_n     = c;
    gt_n    = gt;
    eq_n    = eq;
    lt_n    = lt;

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          sa_n    = cap_a;
          sb_n    = cap_b;
          op_n    = op;
          cnt_n   = CW'(D);
          busy_n  = 1'b1;
          c_n     = 1'b0;
          gt_n    = 1'b0;
          eq_n    = 1'b0;
          lt_n    = 1'b0;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        busy_n = 1'b1;
        if (da > db) begin
          gt_n    = 1'b1;
          c_n     = rel(op_q, 1'b1, 1'b0, 1'b0);
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (da < db) begin
          lt_n    = 1'b1;
          c_n     = rel(op_q, 1'b0, 1'b0, 1'b1);
          done_n  = 1'b1;
          state_n = S_DONE;
        end else if (cnt == CW'(1)) begin
          eq_n    = 1'b1;
          c_n     = rel(op_q, 1'b0, 1'b1, 1'b0);
          done_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          // Digits are equal, so shift the next digit into the compare window.
          sa_n  = sa << K;
          sb_n  = sb << K;
          cnt_n = cnt - CW'(1);
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_magnitude_compare.sv
// Scoreboard bench for serial_magnitude_compare. It uses two instances:
// u1 has N=8, K=1 and u2 has N=8, K=4.
`timescale 1ns/1ps
module tb_serial_magnitude_compare;

  typedef struct {
    logic  gt, eq, lt, c;
    int    lat;
    int    acc;
    string name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic       u1_start, u2_start;
  logic [7:0] u1_a, u1_b, u2_a, u2_b;
  logic [2:0] u1_op, u2_op;
  logic       u1_busy, u1_done, u1_c, u1_gt, u1_eq, u1_lt;
  logic       u2_busy, u2_done, u2_c, u2_gt, u2_eq, u2_lt;
`ifdef SIGNED_COMPARE_EN
  logic       u1_sgn = 1'b0;
  logic       u2_sgn = 1'b0;
`endif

  serial_magnitude_compare #(.N(8), .K(1)) u1 (
    .clk(clk), .rst(rst), .start(u1_start), .a(u1_a), .b(u1_b), .op(u1_op),
`ifdef SIGNED_COMPARE_EN
    .sgn(u1_sgn),
`endif
    .busy(u1_busy), .done(u1_done), .c(u1_c), .gt(u1_gt), .eq(u1_eq), .lt(u1_lt)
  );

  serial_magnitude_compare #(.N(8), .K(4)) u2 (
    .clk(clk), .rst(rst), .start(u2_start), .a(u2_a), .b(u2_b), .op(u2_op),
`ifdef SIGNED_COMPARE_EN
    .sgn(u2_sgn),
`endif
    .busy(u2_busy), .done(u2_done), .c(u2_c), .gt(u2_gt), .eq(u2_eq), .lt(u2_lt)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   u1_ndone = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Check the u1 scoreboard on each done pulse.
  always @(negedge clk) begin
    if (u1_done) begin
      u1_ndone++;
      if (q1.size() == 0) begin
        chk("u1 unexpected done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk({e1.name, " gt"},   int'(u1_gt), int'(e1.gt));
        chk({e1.name, " eq"},   int'(u1_eq), int'(e1.eq));
        chk({e1.name, " lt"},   int'(u1_lt), int'(e1.lt));
        chk({e1.name, " c"},    int'(u1_c),  int'(e1.c));
        chk({e1.name, " busy"}, int'(u1_busy), 1);
        chk({e1.name, " latency"}, cyc - e1.acc, e1.lat);
      end
    end
  end

  // Check the u2 scoreboard on each done pulse.
  always @(negedge clk) begin
    if (u2_done) begin
      if (q2.size() == 0) begin
        chk("u2 unexpected done", 1, 0);
      end else begin
        e2 = q2.pop_front();
        chk({e2.name, " gt"},   int'(u2_gt), int'(e2.gt));
        chk({e2.name, " eq"},   int'(u2_eq), int'(e2.eq));
        chk({e2.name, " lt"},   int'(u2_lt), int'(e2.lt));
        chk({e2.name, " c"},    int'(u2_c),  int'(e2.c));
        chk({e2.name, " latency"}, cyc - e2.acc, e2.lat);
      end
    end
  end

  // Issue one request to u1. After acceptance the inputs are scrambled.
  task automatic issue_u1(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic g, input logic e,
                          input logic l, input logic c, input int lat,
                          input string nm);
    exp_t x;
    @(negedge clk);
    u1_start = 1'b1; u1_a = a; u1_b = b; u1_op = op;
    x.gt = g; x.eq = e; x.lt = l; x.c = c; x.lat = lat; x.acc = cyc; x.name = nm;
    q1.push_back(x);
    @(negedge clk);
    u1_start = 1'b0; u1_a = ~a; u1_b = ~b; u1_op = ~op;
    chk({nm, " busy cyc1"}, int'(u1_busy), 1);
  endtask

  task automatic issue_u2(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic g, input logic e,
                          input logic l, input logic c, input int lat,
                          input string nm);
    exp_t x;
    @(negedge clk);
    u2_start = 1'b1; u2_a = a; u2_b = b; u2_op = op;
    x.gt = g; x.eq = e; x.lt = l; x.c = c; x.lat = lat; x.acc = cyc; x.name = nm;
    q2.push_back(x);
    @(negedge clk);
    u2_start = 1'b0; u2_a = ~a; u2_b = ~b; u2_op = ~op;
    chk({nm, " busy cyc1"}, int'(u2_busy), 1);
  endtask

  // Wait, within a fixed cycle budget, for both instances to drain.
  task automatic drain(input string nm);
    int i;
    i = 0;
    while ((q1.size() != 0 || q2.size() != 0 || u1_busy || u2_busy) && i < 40) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0 || u1_busy || u2_busy)
      chk({nm, " drain timeout"}, 1, 0);
  endtask

  initial begin
    int nd0;
    rst = 1'b1;
    u1_start = 1'b0; u1_a = '0; u1_b = '0; u1_op = '0;
    u2_start = 1'b0; u2_a = '0; u2_b = '0; u2_op = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset u1 outs", int'({u1_busy, u1_done, u1_c, u1_gt, u1_eq, u1_lt}), 0);
    chk("reset u2 outs", int'({u2_busy, u2_done, u2_c, u2_gt, u2_eq, u2_lt}), 0);

    // N=8, K=1 directed vectors.
    issue_u1(8'h80, 8'h7F, 3'b010, 1, 0, 0, 1, 2, "gt80_7f");   drain("v1");
    issue_u1(8'h5A, 8'h5A, 3'b011, 0, 1, 0, 1, 9, "ge5a");      drain("v2");
    issue_u1(8'h5A, 8'h5A, 3'b001, 0, 1, 0, 0, 9, "ne5a");      drain("v3");
    issue_u1(8'h5A, 8'h5A, 3'b111, 0, 1, 0, 0, 9, "rsv7");      drain("v4");
    issue_u1(8'h10, 8'h20, 3'b101, 0, 0, 1, 1, 4, "le10_20");   drain("v5");
    issue_u1(8'h03, 8'h02, 3'b000, 1, 0, 0, 0, 9, "eq03_02");   drain("v6");
    issue_u1(8'h00, 8'h01, 3'b110, 0, 0, 1, 0, 9, "rsv6");      drain("v7");

    // N=8, K=4 directed vectors.
    issue_u2(8'h35, 8'h39, 3'b100, 0, 0, 1, 1, 3, "k4lt35_39"); drain("v8");
    issue_u2(8'h45, 8'h39, 3'b100, 1, 0, 0, 0, 2, "k4lt45_39"); drain("v9");
    issue_u2(8'h77, 8'h77, 3'b101, 0, 1, 0, 1, 3, "k4le77");    drain("v10");

`ifdef SIGNED_COMPARE_EN
    u1_sgn = 1'b1;
    issue_u1(8'hFF, 8'h01, 3'b100, 0, 0, 1, 1, 2, "s_ltff_01"); drain("s1");
    u1_sgn = 1'b0;
    issue_u1(8'hFF, 8'h01, 3'b100, 1, 0, 0, 0, 2, "u_ltff_01"); drain("s2");
`endif

    // A start applied while busy must be ignored.
    @(negedge clk);
    u1_start = 1'b1; u1_a = 8'h01; u1_b = 8'h00; u1_op = 3'b010;
    e1.gt = 1; e1.eq = 0; e1.lt = 0; e1.c = 1; e1.lat = 9; e1.acc = cyc; e1.name = "ign";
    q1.push_back(e1);
    @(negedge clk); u1_start = 1'b0;
    @(negedge clk);
    @(negedge clk); u1_start = 1'b1; u1_a = 8'h00; u1_b = 8'hFF; u1_op = 3'b100;
    @(negedge clk); u1_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ign busy cyc10", int'(u1_busy), 0);
    chk("ign queue empty", q1.size(), 0);
    drain("v11");

    // Reset during a scan aborts it without a done pulse.
    @(negedge clk);
    u1_start = 1'b1; u1_a = 8'hC3; u1_b = 8'hC3; u1_op = 3'b000;
    nd0 = u1_ndone;
    @(negedge clk); u1_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort outs cyc5", int'({u1_busy, u1_done, u1_c, u1_gt, u1_eq, u1_lt}), 0);
    repeat (12) @(negedge clk);
    chk("abort no done", u1_ndone, nd0);
    issue_u1(8'hC3, 8'hC3, 3'b000, 0, 1, 0, 1, 9, "post_rst");  drain("v12");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
